// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : byte-stream command sequencer driving the 8-bit add/sub ALU
// Optional macro ALU_SEQ_SAT_EN : signed saturation of overflowed results
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_first,
  output logic [7:0] alu_second,
  output logic       alu_add_sub_n,
  input  logic [7:0] alu_result,
  input  logic       alu_z,
  input  logic       alu_s,
  input  logic       alu_v,
  output logic [7:0] out_data,
  output logic [2:0] out_flags,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    EXEC  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       in_fire;
  logic       out_fire;
  logic       timeout;
  logic       err_nx;
  logic       opcode_ok;
  logic [7:0] exec_data;
  logic [2:0] exec_flags;

  assign in_ready  = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign busy      = (state != IDLE);
  assign out_valid = (state == RESP);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign opcode_ok = (in_data[7:1] == 7'd0);

  generate
    if (TIMEOUT_CYC != 0) begin : g_timeout
      logic [CNT_W-1:0] cnt;
      logic             waiting;

      assign waiting = (state == GET_A) || (state == GET_B);
      // An accepted byte wins over an expiring count, so no handshaken byte is lost.
      assign timeout = waiting && !in_fire && (cnt == CNT_W'(TIMEOUT_CYC));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (waiting && !in_fire && !timeout) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          cnt <= '0;
        end
      end
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          if (opcode_ok) state_nx = GET_A;
          else           err_nx   = 1'b1;
        end
      end
      GET_A: begin
        if (timeout) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else if (in_fire) begin
          state_nx = GET_B;
        end
      end
      GET_B: begin
        if (timeout) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else if (in_fire) begin
          state_nx = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (out_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef ALU_SEQ_SAT_EN
  // Wrapped sign bit is the inverse of the true sign when overflow occurred.
  always_comb begin
    exec_data  = alu_result;
    exec_flags = {alu_v, alu_s, alu_z};
    if (alu_v) begin
      exec_data  = alu_result[7] ? 8'h7F : 8'h80;
      exec_flags = {1'b1, exec_data[7], (exec_data == 8'h00)};
    end
  end
`else
  assign exec_data  = alu_result;
  assign exec_flags = {alu_v, alu_s, alu_z};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_first     <= 8'h00;
      alu_second    <= 8'h00;
      alu_add_sub_n <= 1'b0;
      out_data      <= 8'h00;
      out_flags     <= 3'b000;
      err           <= 1'b0;
    end else begin
      err <= err_nx;
      if (in_fire && (state == IDLE) && opcode_ok) alu_add_sub_n <= in_data[0];
      if (in_fire && (state == GET_A))             alu_first     <= in_data;
      if (in_fire && (state == GET_B))             alu_second    <= in_data;
      if (state == EXEC) begin
        out_data  <= exec_data;
        out_flags <= exec_flags;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer : randomized self-checking bench with an ALU model and a reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] alu_first;
  logic [7:0] alu_second;
  logic       alu_add_sub_n;
  logic [7:0] alu_result;
  logic       alu_z;
  logic       alu_s;
  logic       alu_v;
  logic [7:0] alu_b_eff;
  logic [7:0] out_data;
  logic [2:0] out_flags;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_first(alu_first), .alu_second(alu_second), .alu_add_sub_n(alu_add_sub_n),
    .alu_result(alu_result), .alu_z(alu_z), .alu_s(alu_s), .alu_v(alu_v),
    .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Gate-level style add/sub ALU the sequencer feeds.
  always_comb begin
    alu_b_eff  = alu_add_sub_n ? alu_second : ~alu_second;
    alu_result = alu_first + alu_b_eff + {7'd0, ~alu_add_sub_n};
    alu_z      = (alu_result == 8'h00);
    alu_s      = alu_result[7];
    alu_v      = (alu_first[7] == alu_b_eff[7]) && (alu_result[7] != alu_first[7]);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {flags, data} from signed integer arithmetic.
  function automatic logic [10:0] ref_model(input logic op, input logic [7:0] a, input logic [7:0] b);
    int         sa;
    int         sb;
    int         r;
    logic       v;
    logic [7:0] d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = op ? (sa + sb) : (sa - sb);
    v  = (r > 127) || (r < -128);
    d  = r[7:0];
`ifdef ALU_SEQ_SAT_EN
    if (v) d = (r > 127) ? 8'h7F : 8'h80;
`endif
    return {v, d[7], (d == 8'h00), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_val(tag, 32'({out_valid, out_data, out_flags, err, busy, alu_first, alu_second, alu_add_sub_n}), 32'd0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check_val("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [10:0] exp, input int delay);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    repeat (delay) tick();
    check_val({tag, "_data"}, 32'(out_data), 32'(exp[7:0]));
    check_val({tag, "_flags"}, 32'(out_flags), 32'(exp[10:8]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_idle"}, 32'({out_valid, busy}), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic op, input logic [7:0] a, input logic [7:0] b,
                         input int gap_max, input int delay);
    send({7'd0, op}, $urandom_range(0, gap_max));
    send(a, $urandom_range(0, gap_max));
    send(b, $urandom_range(0, gap_max));
    collect(tag, ref_model(op, a, b), delay);
  endtask

  initial begin
    logic       saw_valid;
    logic [7:0] bad;

    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Add with latency and backpressure checks.
    send(8'h01, 0);
    send(8'h05, 0);
    send(8'h03, 0);
    check_val("lat_exec_valid", 32'({out_valid, in_ready, busy}), 32'b001);
    tick();
    tick();
    check_val("lat_resp_valid", 32'(out_valid), 32'd1);
    check_val("add_data", 32'(out_data), 32'h08);
    check_val("add_flags", 32'(out_flags), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp_hold", 32'({out_valid, in_ready, out_data, out_flags}), 32'({2'b10, 8'h08, 3'b000}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("bp_release", 32'({out_valid, busy, in_ready}), 32'b001);

    run_cmd("sub_zero", 1'b0, 8'h2A, 8'h2A, 0, 0);
    run_cmd("sub_neg", 1'b0, 8'h01, 8'h02, 0, 1);
    run_cmd("add_ovf", 1'b1, 8'h7F, 8'h01, 0, 0);
    run_cmd("sub_ovf", 1'b0, 8'h80, 8'h01, 0, 2);

    // Bad opcode.
    send(8'h02, 0);
    check_val("badop_err", 32'({err, busy}), 32'b10);
    tick();
    check_val("badop_err_drop", 32'(err), 32'd0);

    // Inter-byte timeout drops the partial command.
    send(8'h01, 0);
    send(8'h05, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (err) break;
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check_val("tmo_err", 32'({err, busy}), 32'b10);
    check_val("tmo_no_resp", 32'(saw_valid), 32'd0);
    tick();
    check_val("tmo_err_drop", 32'(err), 32'd0);
    run_cmd("after_tmo", 1'b1, 8'h01, 8'h01, 0, 0);

    // Asynchronous reset in GET_B.
    send(8'h00, 0);
    send(8'h10, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_getb");
    #2 rst_n = 1'b1;
    tick();
    run_cmd("after_rst_getb", 1'b1, 8'h20, 8'h03, 0, 0);

    // Asynchronous reset in RESP.
    send(8'h01, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    tick();
    tick();
    check_val("pre_rst_resp", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_resp");
    #2 rst_n = 1'b1;
    tick();
    run_cmd("after_rst_resp", 1'b0, 8'h09, 8'h04, 0, 0);

    // Randomized commands with interleaved bad opcodes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bad = 8'($urandom_range(2, 255));
        send(bad, $urandom_range(0, 2));
        check_val("rnd_badop_err", 32'({err, busy}), 32'b10);
      end
      run_cmd("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 2, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
